ps2_rx_ctrl: RTL and testbench
==============================

Name: ps2_rx_ctrl

Overview:
- Receive-side controller for the PS/2 keyboard port (PS2CLK/PS2DATA) of the OTTER wrapper.
- Synchronizes and glitch-filters the PS/2 lines, then runs the 11-bit frame sequencer (start, 8 data LSB-first, odd parity, stop).
- Buffers good scancodes in a small FWFT FIFO and presents them to the MCU as a memory-mapped read port with an interrupt pulse and sticky error/overflow flags.

Parameters:
- FILTER_LEN, 8: consecutive stable cycles required before the filtered PS2CLK changes state.
- TIMEOUT_CYC, 5000: idle cycles between falling edges mid-frame before the partial frame is abandoned.
- FIFO_DEPTH, 4: scancode buffer entries (power of 2, >=2).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- PS2CLK  in  1  raw keyboard clock (asynchronous)
- PS2DATA  in  1  raw keyboard data (asynchronous)
- RD  in  1  pop strobe from MCU bus, one cycle
- ERR_CLR  in  1  clears ERR and OVF
- DOUT  out  8  FIFO head scancode
- VALID  out  1  FIFO non-empty
- INTR  out  1  one-cycle pulse per byte accepted into FIFO
- ERR  out  1  sticky parity/stop-bit error
- OVF  out  1  sticky FIFO overflow

Behaviour:
- Reset: all outputs 0; FIFO empty; FSM IDLE; filtered clock = 1; sync flops = 1; counters 0.
- Sync/filter:
  - Both lines pass through 2-flop synchronizers.
  - Filtered clock takes the synced value only after it has differed from the filtered value for FILTER_LEN consecutive cycles; any agreeing cycle resets the count.
  - Data is synchronized only, not filtered.
- Edge detection: FALL = previous filtered clock 1 and current 0. Synced data is sampled in the FALL cycle.
- Fixed latency: a raw PS2CLK falling edge that stays low produces FALL exactly FILTER_LEN+3 cycles later.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on FALL with data 0, go to DATA and set bitcnt=0. On FALL with data 1, stay in IDLE; no flag.
  - DATA: on FALL, shift data into shreg[7] with a right-shift, so bits land LSB-first; bitcnt++. After the 8th bit, go to PARITY.
  - PARITY: on FALL, latch the parity bit and go to STOP.
  - STOP: on FALL, go to IDLE. The frame is good iff the stop bit is 1 and ^{shreg,parity}==1.
- Good frame: the FIFO write takes effect the cycle after the stop FALL. VALID, DOUT and the INTR pulse appear in that same next cycle.
- Bad frame: byte discarded; ERR set the cycle after the stop FALL.
- Timeout: a counter clears on every FALL and counts while state!=IDLE. When it reaches TIMEOUT_CYC, the FSM goes to IDLE, the partial frame is discarded, and no flag is set.
- FIFO:
  - First-word fall-through; DOUT = head when VALID, else 8'h00.
  - RD with VALID pops on that clock edge. RD when empty is ignored.
  - Push into a full FIFO drops the new byte, sets OVF, and suppresses INTR.
  - Push and pop in the same cycle when full: both succeed, no OVF, INTR pulses.
  - Pointers wrap modulo FIFO_DEPTH; the count is FIFO_DEPTH+1 states wide.
- Flags: ERR_CLR clears ERR and OVF. A set event in the same cycle as ERR_CLR wins.
- RST mid-frame: abandons the frame, empties the FIFO, clears flags next cycle; no INTR.

Decomposition:
- Shared package ps2_pkg:
  - typedef enum ps2_state_t {IDLE, DATA, PARITY, STOP}
  - constants PS2_DATA_BITS=8, PS2_FRAME_BITS=11
  - scancode constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0 for software-facing tests.
- One sub-module, ps2_sync_filter: 2-flop synchronizers, filter counter, FALL generation, and synced-data output.
- FSM, FIFO and flags stay in ps2_rx_ctrl.

Test Plan:
- Good frame 0x1C: send start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1, with 2000-cycle clock half-periods.
  -> VALID=1 and DOUT=8'h1C the cycle after the stop FALL; INTR high exactly 1 cycle; ERR=0.
  -> RD then VALID=0, DOUT=8'h00.
- Parity error: send 0xF0 with parity 0 (correct parity is 1).
  -> no push, VALID stays 0, ERR=1.
  -> ERR_CLR pulse -> ERR=0.
- Glitch rejection: during IDLE, drive a PS2CLK low pulse of FILTER_LEN-1 cycles.
  -> no FALL, FSM stays IDLE.
  -> A following 0x1C frame is received correctly.
- Timeout: send start plus 3 data bits, then hold PS2CLK high for 6000 cycles.
  -> FSM returns to IDLE; no ERR, no push.
  -> Next full 0x1C frame is received intact.
- Overflow: send 5 good frames 0x01..0x05 with no RD.
  -> 4 INTR pulses; 5th frame sets OVF with no INTR.
  -> Reads return 0x01..0x04 in order.
  -> Then with FIFO full, assert RD on the push cycle of a 6th frame 0x06 -> no OVF change, INTR pulses.
- Reset mid-frame: assert RST after 5 bits of a frame.
  -> all outputs 0 next cycle.
  -> Subsequent clean frame 0x2A received, DOUT=8'h2A.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Frame layout: start, 8 data bits LSB-first, odd parity, stop.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes PS2CLK/PS2DATA, debounces the clock and
// produces a one-cycle FALL strobe plus the synced data bit.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          c_s1, c_s2;
  logic          d_s1, d_s2;
  logic          filt, prev;
  logic [FW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
      filt <= 1'b1;
      prev <= 1'b1;
      cnt  <= '0;
    end else begin
      c_s1 <= ps2_clk;
      c_s2 <= c_s1;
      d_s1 <= ps2_data;
      d_s2 <= d_s1;
      prev <= filt;
      // any agreeing cycle restarts the stability count
      if (c_s2 == filt) begin
        cnt <= '0;
      end else if (cnt == FW'(FILTER_LEN - 1)) begin
        filt <= c_s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + FW'(1);
      end
    end
  end

  assign fall   = prev & ~filt;
  assign data_s = d_s2;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: frame FSM, scancode FWFT FIFO,
// interrupt pulse and sticky error/overflow flags.
module ps2_rx_ctrl #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2CLK,
  input  logic       PS2DATA,
  input  logic       RD,
  input  logic       ERR_CLR,
  output logic [7:0] DOUT,
  output logic       VALID,
  output logic       INTR,
  output logic       ERR,
  output logic       OVF
);

  import ps2_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          fall, sdata;
  ps2_state_t    state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic stop_fall, good, bad;
  logic full, pop, wr, drop, tout;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk     (CLK),
    .rst     (RST),
    .ps2_clk (PS2CLK),
    .ps2_data(PS2DATA),
    .fall    (fall),
    .data_s  (sdata)
  );

  assign stop_fall = fall && (state == STOP);
  assign good = stop_fall && sdata && odd_ok(shreg, par);
  assign bad  = stop_fall && !good;
  assign tout = (state != IDLE) && !fall
             && (tcnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (fall || state == IDLE) tcnt <= '0;
      else tcnt <= tcnt + TW'(1);
      unique case (state)
        IDLE: if (fall && !sdata) begin
          state  <= DATA;
          bitcnt <= '0;
        end
        DATA: if (fall) begin
          shreg  <= {sdata, shreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'(PS2_DATA_BITS - 1))
            state <= PARITY;
        end
        PARITY: if (fall) begin
          par   <= sdata;
          state <= STOP;
        end
        STOP: if (fall) state <= IDLE;
      endcase
      if (tout) state <= IDLE;
    end
  end

  assign full  = (count == CW'(FIFO_DEPTH));
  assign VALID = (count != '0);
  assign pop   = RD && VALID;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign wr    = good && (!full || pop);
  assign drop  = good && full && !pop;
  assign DOUT  = VALID ? mem[rptr] : 8'h00;

  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= shreg;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      INTR  <= 1'b0;
      ERR   <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(wr) - CW'(pop);
      INTR  <= wr;
      if (bad)          ERR <= 1'b1;
      else if (ERR_CLR) ERR <= 1'b0;
      if (drop)         OVF <= 1'b1;
      else if (ERR_CLR) OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: frames, errors, glitch,
// timeout, overflow and mid-frame reset scenarios.
module tb_ps2_rx_ctrl;

  import ps2_pkg::*;

  localparam int FL = 8;
  localparam int TO = 5000;
  localparam int HP = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dout;
  logic       valid, intr, err, ovf;

  int n_vec = 0;
  int n_miss = 0;
  int intr_cnt = 0;

  logic       pre_valid, pre_intr, next_intr;
  logic       post_valid, post_intr, post_err, post_ovf;
  logic [7:0] post_dout;

  ps2_rx_ctrl #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .PS2CLK (ps2_clk),
    .PS2DATA(ps2_data),
    .RD     (rd),
    .ERR_CLR(err_clr),
    .DOUT   (dout),
    .VALID  (valid),
    .INTR   (intr),
    .ERR    (err),
    .OVF    (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (intr === 1'b1) intr_cnt++;

  function automatic logic [10:0] frame_bits(
    input logic [7:0] b,
    input logic       par_ok
  );
    logic p;
    p = par_ok ? ~^b : ^b;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(
    input logic [7:0] b,
    input logic       par_ok,
    input int         half,
    input logic       rd_push
  );
    logic [10:0] bits;
    bits = frame_bits(b, par_ok);
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (FL + 2) @(posedge clk);
        @(negedge clk);
        pre_valid = valid;
        pre_intr  = intr;
        if (rd_push) rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        post_valid = valid;
        post_intr  = intr;
        post_dout  = dout;
        post_err   = err;
        post_ovf   = ovf;
        @(negedge clk);
        next_intr = intr;
        repeat (half - FL - 4) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    repeat (half) @(negedge clk);
  endtask

  task automatic do_read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({dout, valid, intr, err, ovf} !== 12'h000) begin
      n_miss++;
      $display("FAIL reset_outs got %h want 000",
               {dout, valid, intr, err, ovf});
    end
    n_vec++;
    if (dut.state !== IDLE) begin
      n_miss++;
      $display("FAIL reset_state got %0d want IDLE", dut.state);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good_frame();
    send_frame(8'h1C, 1'b1, 2000, 1'b0);
    n_vec++;
    if ({pre_valid, pre_intr} !== 2'b00) begin
      n_miss++;
      $display("FAIL good_pre got %b want 00", {pre_valid, pre_intr});
    end
    n_vec++;
    if ({post_valid, post_intr, next_intr, post_err} !== 4'b1100) begin
      n_miss++;
      $display("FAIL good_flags got %b want 1100",
               {post_valid, post_intr, next_intr, post_err});
    end
    n_vec++;
    if (post_dout !== 8'h1C) begin
      n_miss++;
      $display("FAIL good_dout got %h want 1c", post_dout);
    end
    do_read();
    n_vec++;
    if ({valid, dout} !== 9'h000) begin
      n_miss++;
      $display("FAIL good_read got %b/%h want 0/00", valid, dout);
    end
  endtask

  task automatic test_parity_err();
    send_frame(PS2_BREAK, 1'b0, HP, 1'b0);
    n_vec++;
    if ({post_valid, post_intr, post_err} !== 3'b001) begin
      n_miss++;
      $display("FAIL parity_flags got %b want 001",
               {post_valid, post_intr, post_err});
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++;
    if (err !== 1'b0) begin
      n_miss++;
      $display("FAIL parity_clr got %b want 0", err);
    end
  endtask

  task automatic test_glitch();
    ps2_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk);
    n_vec++;
    if (dut.state !== IDLE || valid !== 1'b0 || err !== 1'b0) begin
      n_miss++;
      $display("FAIL glitch_idle got st=%0d v=%b e=%b want IDLE/0/0",
               dut.state, valid, err);
    end
    send_frame(8'h1C, 1'b1, HP, 1'b0);
    n_vec++;
    if ({post_valid, post_intr, post_dout} !== {2'b11, 8'h1C}) begin
      n_miss++;
      $display("FAIL glitch_frame got %b/%b/%h want 1/1/1c",
               post_valid, post_intr, post_dout);
    end
    do_read();
  endtask

  task automatic test_timeout();
    send_bits(frame_bits(8'h1C, 1'b1), 4);
    repeat (3000) @(negedge clk);
    n_vec++;
    if (dut.state !== DATA) begin
      n_miss++;
      $display("FAIL timeout_early got %0d want DATA", dut.state);
    end
    repeat (3000) @(negedge clk);
    n_vec++;
    if (dut.state !== IDLE || err !== 1'b0 || valid !== 1'b0) begin
      n_miss++;
      $display("FAIL timeout_idle got st=%0d e=%b v=%b want IDLE/0/0",
               dut.state, err, valid);
    end
    send_frame(8'h1C, 1'b1, HP, 1'b0);
    n_vec++;
    if ({post_valid, post_err, post_dout} !== {2'b10, 8'h1C}) begin
      n_miss++;
      $display("FAIL timeout_next got %b/%b/%h want 1/0/1c",
               post_valid, post_err, post_dout);
    end
    do_read();
  endtask

  task automatic test_overflow();
    int c0;
    logic [7:0] exp_q [4];
    c0 = intr_cnt;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, HP, 1'b0);
      n_vec++;
      if ({post_intr, post_ovf} !== ((k <= 4) ? 2'b10 : 2'b01)) begin
        n_miss++;
        $display("FAIL ovf_frame%0d got intr=%b ovf=%b", k,
                 post_intr, post_ovf);
      end
    end
    n_vec++;
    if (intr_cnt - c0 !== 4) begin
      n_miss++;
      $display("FAIL ovf_intr_cnt got %0d want 4", intr_cnt - c0);
    end
    for (int k = 1; k <= 4; k++) begin
      n_vec++;
      if ({valid, dout} !== {1'b1, 8'(k)}) begin
        n_miss++;
        $display("FAIL ovf_read%0d got %b/%h want 1/%h", k,
                 valid, dout, 8'(k));
      end
      do_read();
    end
    n_vec++;
    if (valid !== 1'b0) begin
      n_miss++;
      $display("FAIL ovf_empty got %b want 0", valid);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++;
    if (ovf !== 1'b0) begin
      n_miss++;
      $display("FAIL ovf_clr got %b want 0", ovf);
    end
    for (int k = 0; k < 4; k++) send_frame(8'h11 + 8'(k), 1'b1, HP, 1'b0);
    send_frame(8'h06, 1'b1, HP, 1'b1);
    n_vec++;
    if ({pre_valid, post_intr, post_ovf, post_valid} !== 4'b1101) begin
      n_miss++;
      $display("FAIL ovf_pushpop got %b want 1101",
               {pre_valid, post_intr, post_ovf, post_valid});
    end
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h06};
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({valid, dout} !== {1'b1, exp_q[k]}) begin
        n_miss++;
        $display("FAIL ovf_drain%0d got %b/%h want 1/%h", k,
                 valid, dout, exp_q[k]);
      end
      do_read();
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h55, 1'b1, HP, 1'b0);
    send_frame(PS2_EXT, 1'b0, HP, 1'b0);
    n_vec++;
    if ({valid, err} !== 2'b11) begin
      n_miss++;
      $display("FAIL rstmid_pre got %b want 11", {valid, err});
    end
    send_bits(frame_bits(8'h2A, 1'b1), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({dout, valid, intr, err, ovf} !== 12'h000) begin
      n_miss++;
      $display("FAIL rstmid_outs got %h want 000",
               {dout, valid, intr, err, ovf});
    end
    @(negedge clk);
    n_vec++;
    if (intr !== 1'b0 || dut.state !== IDLE) begin
      n_miss++;
      $display("FAIL rstmid_idle got intr=%b st=%0d want 0/IDLE",
               intr, dut.state);
    end
    send_frame(8'h2A, 1'b1, HP, 1'b0);
    n_vec++;
    if ({post_valid, post_intr, post_err, post_dout}
        !== {3'b110, 8'h2A}) begin
      n_miss++;
      $display("FAIL rstmid_frame got %b/%b/%b/%h want 1/1/0/2a",
               post_valid, post_intr, post_err, post_dout);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_glitch();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
